// File: rtl/router_pkg.sv
// Shared defaults and helpers for the 1xN stream router.
package router_pkg;

   localparam int DATA_W_DEF     = 8;
   localparam int N_OUT_DEF      = 3;
   localparam int FIFO_DEPTH_DEF = 4;

   // Address width never drops below one bit, even for a two-port router.
   function automatic int addr_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/router_fifo.sv
// First-word-fall-through FIFO for one router output port.
module router_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic              empty,
   output logic              full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0]      wr_ptr;
   logic [PTR_W:0]      rd_ptr;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   last_q;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   // Once drained, the port keeps showing the last beat it delivered.
   assign head_data = empty ? last_q : mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         last_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push && !full) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
            wr_ptr                 <= wr_ptr + (PTR_W+1)'(1);
         end
         if (pop && !empty) begin
            last_q <= mem[rd_ptr[PTR_W-1:0]];
            rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         end
      end
   end

endmodule

// File: rtl/router_1xn.sv
// Steers one ingress stream to N_OUT buffered output ports by per-beat address.
module router_1xn
   import router_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int N_OUT      = N_OUT_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int CNT_W      = 16,
   localparam int ADDR_W    = addr_width(N_OUT)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_W-1:0]       data_in,
   input  logic                    valid_in,
   input  logic [ADDR_W-1:0]       addr,
   output logic                    ready_in,
   output logic [N_OUT*DATA_W-1:0] data_out,
   output logic [N_OUT-1:0]        valid_out,
   input  logic [N_OUT-1:0]        ready_out,
   output logic [N_OUT-1:0]        fifo_full,
   output logic [CNT_W-1:0]        drop_cnt,
   output logic                    drop_pulse
);

   logic [N_OUT-1:0] push;
   logic [N_OUT-1:0] pop;
   logic [N_OUT-1:0] empty;
   logic             drop;

   // Out-of-range addresses are always accepted so they can be discarded.
   always_comb begin
      ready_in = 1'b1;
      push     = '0;
      for (int i = 0; i < N_OUT; i++) begin
         if (int'(addr) == i) begin
            ready_in = !fifo_full[i];
            push[i]  = valid_in && !fifo_full[i];
         end
      end
   end

   assign drop = valid_in && (int'(addr) >= N_OUT);
   assign pop  = valid_out & ready_out;

   for (genvar i = 0; i < N_OUT; i++) begin : g_port
      router_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (FIFO_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (push[i]),
         .push_data (data_in),
         .pop       (pop[i]),
         .head_data (data_out[i*DATA_W +: DATA_W]),
         .empty     (empty[i]),
         .full      (fifo_full[i])
      );
      assign valid_out[i] = !empty[i];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt   <= '0;
         drop_pulse <= 1'b0;
      end else begin
         drop_pulse <= drop;
         if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
         end
      end
   end

endmodule
